// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator layer sequencing: phase encoding,
// layer-to-phase mapping and default lengths of the fixed-size layers.
package accel_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_DEPTH = 3'd2,
    PH_POINT = 3'd3,
    PH_POOL  = 3'd4,
    PH_FLAT  = 3'd5,
    PH_FC1   = 3'd6,
    PH_FC2   = 3'd7
  } phase_e;

  typedef enum logic {
    ST_COUNTING = 1'b0,
    ST_FIRED    = 1'b1
  } track_state_e;

  localparam int unsigned PROG_W = 20;

  localparam logic [3:0] LAYER_FLAT = 4'd12;
  localparam logic [3:0] LAYER_FC1  = 4'd13;
  localparam logic [3:0] LAYER_FC2  = 4'd14;

  localparam int unsigned FLAT_LEN_DEFAULT = 1024;
  localparam int unsigned FC1_LEN_DEFAULT  = 128;
  localparam int unsigned FC2_LEN_DEFAULT  = 10;

  // Layers 0..11 repeat the conv group INIT/DEPTH/POINT/POOL three times.
  function automatic phase_e layer_to_phase(input logic [3:0] layer);
    phase_e ph;
    ph = PH_IDLE;
    if (layer < LAYER_FLAT) begin
      case (layer[1:0])
        2'd0:    ph = PH_INIT;
        2'd1:    ph = PH_DEPTH;
        2'd2:    ph = PH_POINT;
        default: ph = PH_POOL;
      endcase
    end else if (layer == LAYER_FLAT) begin
      ph = PH_FLAT;
    end else if (layer == LAYER_FC1) begin
      ph = PH_FC1;
    end else if (layer == LAYER_FC2) begin
      ph = PH_FC2;
    end
    return ph;
  endfunction

endpackage

// File: rtl/phase_target_calc.sv
// Combinational element-count target for the current phase, computed from the
// layer geometry and clamped to the 20-bit progress range.
module phase_target_calc
  import accel_pkg::*;
#(
  parameter int unsigned FLAT_LEN = FLAT_LEN_DEFAULT,
  parameter int unsigned FC1_LEN  = FC1_LEN_DEFAULT,
  parameter int unsigned FC2_LEN  = FC2_LEN_DEFAULT
) (
  input  logic [2:0]        phase,
  input  logic [7:0]        input_size,
  input  logic [7:0]        output_size,
  input  logic [7:0]        input_channel,
  input  logic [7:0]        output_channel,
  output logic [PROG_W-1:0] target
);

  logic [15:0] out_sq;
  logic [13:0] half_sq;
  logic [23:0] wide;

  assign out_sq  = 16'(output_size) * 16'(output_size);
  assign half_sq = 14'(output_size >> 1) * 14'(output_size >> 1);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wide = '0;
    case (phase_e'(phase))
      PH_INIT:  wide = 24'(input_size) * 24'd3;
      PH_DEPTH: wide = 24'(out_sq) * 24'(input_channel);
      PH_POINT: wide = 24'(out_sq) * 24'(output_channel);
      PH_POOL:  wide = 24'(half_sq) * 24'(output_channel);
      PH_FLAT:  wide = 24'(FLAT_LEN);
      PH_FC1:   wide = 24'(FC1_LEN);
      PH_FC2:   wide = 24'(FC2_LEN);
      default:  wide = '0;
    endcase
  end

  // Geometries beyond the 20-bit range saturate rather than wrap.
  assign target = (wide > 24'hF_FFFF) ? 20'hF_FFFF : wide[PROG_W-1:0];

endmodule

// File: rtl/layer_progress_tracker.sv
// Counts produced elements per sequencer phase and pulses that phase's done
// output once the geometry-derived target is reached. Optional watchdog: PROGRESS_TIMEOUT_EN.
module layer_progress_tracker
  import accel_pkg::*;
#(
  parameter int unsigned FLAT_LEN       = FLAT_LEN_DEFAULT,
  parameter int unsigned FC1_LEN        = FC1_LEN_DEFAULT,
  parameter int unsigned FC2_LEN        = FC2_LEN_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        layer,
  input  logic [7:0]        input_size,
  input  logic [7:0]        output_size,
  input  logic [7:0]        input_channel,
  input  logic [7:0]        output_channel,
  input  logic              in_valid,
  input  logic              depth_valid,
  input  logic              point_valid,
  input  logic              pool_valid,
  input  logic              flat_valid,
  input  logic              fc_valid,
  output logic              init_buffer_done,
  output logic              depth_done,
  output logic              point_done,
  output logic              POOL_done,
  output logic              flatten_done,
  output logic              fc1_done,
  output logic              fc2_done,
  output logic [2:0]        phase,
  output logic [PROG_W-1:0] progress,
  output logic              stall_err
);

  phase_e            cur_phase, phase_q;
  track_state_e      state_q, state_d, st_eff;
  logic [PROG_W-1:0] target, progress_q, progress_d, base;
  logic [PROG_W:0]   sum;
  logic [6:0]        done_q, done_d;
  logic [3:0]        prev_layer_q;
  logic              strobe, layer_change;

  assign cur_phase    = layer_to_phase(layer);
  assign layer_change = (layer != prev_layer_q);

  phase_target_calc #(
    .FLAT_LEN (FLAT_LEN),
    .FC1_LEN  (FC1_LEN),
    .FC2_LEN  (FC2_LEN)
  ) u_target (
    .phase          (cur_phase),
    .input_size     (input_size),
    .output_size    (output_size),
    .input_channel  (input_channel),
    .output_channel (output_channel),
    .target         (target)
  );

  always_comb begin
    strobe = 1'b0;
    case (cur_phase)
      PH_INIT:         strobe = in_valid;
      PH_DEPTH:        strobe = depth_valid;
      PH_POINT:        strobe = point_valid;
      PH_POOL:         strobe = pool_valid;
      PH_FLAT:         strobe = flat_valid;
      PH_FC1, PH_FC2:  strobe = fc_valid;
      default:         strobe = 1'b0;
    endcase
  end

  // A layer change restarts counting in the same cycle, so its strobe is element one.
  always_comb begin
    base       = layer_change ? '0 : progress_q;
    st_eff     = layer_change ? ST_COUNTING : state_q;
    progress_d = base;
    state_d    = st_eff;
    done_d     = '0;
    sum        = {1'b0, base} + (PROG_W + 1)'(strobe);
    if (st_eff == ST_COUNTING && cur_phase != PH_IDLE) begin
      if (sum >= {1'b0, target}) begin
        progress_d = target;
        state_d    = ST_FIRED;
        done_d     = 7'b1 << (3'(cur_phase) - 3'd1);
      end else begin
        progress_d = sum[PROG_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_layer_q <= '0;
      progress_q   <= '0;
      state_q      <= ST_COUNTING;
      done_q       <= '0;
      phase_q      <= PH_IDLE;
    end else begin
      prev_layer_q <= layer;
      progress_q   <= progress_d;
      state_q      <= state_d;
      done_q       <= done_d;
      phase_q      <= cur_phase;
    end
  end

  assign init_buffer_done = done_q[0];
  assign depth_done       = done_q[1];
  assign point_done       = done_q[2];
  assign POOL_done        = done_q[3];
  assign flatten_done     = done_q[4];
  assign fc1_done         = done_q[5];
  assign fc2_done         = done_q[6];
  assign phase            = phase_q;
  assign progress         = progress_q;

`ifdef PROGRESS_TIMEOUT_EN
  logic [31:0] idle_cnt_q;
  logic        stall_q;
  logic        counted;

  assign counted = strobe && (st_eff == ST_COUNTING) && (cur_phase != PH_IDLE);

  // Only an unfinished, non-idle phase can stall; a fired phase is waiting on the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else if (layer_change || counted) begin
      idle_cnt_q <= '0;
    end else if (st_eff == ST_COUNTING && cur_phase != PH_IDLE && !stall_q) begin
      idle_cnt_q <= idle_cnt_q + 32'd1;
      if (idle_cnt_q + 32'd1 >= TIMEOUT_CYCLES) stall_q <= 1'b1;
    end
  end

  assign stall_err = stall_q;
`else
  assign stall_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_layer_progress_tracker.sv
// Directed bench for layer_progress_tracker: a table of per-phase vectors plus
// hand-written reset and re-entry sequences.
module tb_layer_progress_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  layer = 4'd0;
  logic [7:0]  input_size = '0, output_size = '0, input_channel = '0, output_channel = '0;
  logic [5:0]  strb = '0;
  logic        init_buffer_done, depth_done, point_done, POOL_done, flatten_done, fc1_done, fc2_done;
  logic [2:0]  phase;
  logic [19:0] progress;
  logic        stall_err;
  logic [6:0]  done_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign done_v = {fc2_done, fc1_done, flatten_done, POOL_done, point_done, depth_done, init_buffer_done};

  layer_progress_tracker dut (
    .clk              (clk),
    .rst              (rst),
    .layer            (layer),
    .input_size       (input_size),
    .output_size      (output_size),
    .input_channel    (input_channel),
    .output_channel   (output_channel),
    .in_valid         (strb[0]),
    .depth_valid      (strb[1]),
    .point_valid      (strb[2]),
    .pool_valid       (strb[3]),
    .flat_valid       (strb[4]),
    .fc_valid         (strb[5]),
    .init_buffer_done (init_buffer_done),
    .depth_done       (depth_done),
    .point_done       (point_done),
    .POOL_done        (POOL_done),
    .flatten_done     (flatten_done),
    .fc1_done         (fc1_done),
    .fc2_done         (fc2_done),
    .phase            (phase),
    .progress         (progress),
    .stall_err        (stall_err)
  );

  typedef struct {
    int layer;
    int in_size;
    int out_size;
    int in_ch;
    int out_ch;
    int strobe_bit;
    int other_mask;
    int n_strobes;
    int fire_at;
    int exp_prog;
    int exp_phase;
    int done_bit;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int pulses, pulse_step, stray, cycles;
    pulses = 0; pulse_step = 0; stray = 0;
    strb  = '0;
    layer = (v.layer == 15) ? 4'd14 : 4'd15;
    step();
    input_size     = 8'(v.in_size);
    output_size    = 8'(v.out_size);
    input_channel  = 8'(v.in_ch);
    output_channel = 8'(v.out_ch);
    layer          = 4'(v.layer);
    cycles = ((v.n_strobes > v.fire_at) ? v.n_strobes : v.fire_at) + 3;
    for (int s = 1; s <= cycles; s++) begin
      strb = (s <= v.n_strobes) ? (6'(1 << v.strobe_bit) | 6'(v.other_mask)) : 6'd0;
      step();
      for (int b = 0; b < 7; b++) begin
        if (done_v[b]) begin
          if (b == v.done_bit) begin
            pulses++;
            pulse_step = s;
          end else begin
            stray++;
          end
        end
      end
    end
    strb = '0;
    check($sformatf("vec%0d_pulses", idx), pulses, (v.done_bit >= 0) ? 1 : 0);
    check($sformatf("vec%0d_pulse_step", idx), pulse_step, v.fire_at);
    check($sformatf("vec%0d_stray_done", idx), stray, 0);
    check($sformatf("vec%0d_progress", idx), int'(progress), v.exp_prog);
    check($sformatf("vec%0d_phase", idx), int'(phase), v.exp_phase);
  endtask

  initial begin
    int pulses, pulse_step, stray;

    //            layer in  out ich och bit other  n      fire   prog   ph done
    vecs[0]  = '{0,  32, 0,  0,  0,  0,  0,  100,   96,    96,    1, 0};
    vecs[1]  = '{1,  0,  32, 3,  0,  1,  0,  3082,  3072,  3072,  2, 1};
    vecs[2]  = '{7,  0,  16, 0,  32, 3,  4,  2048,  2048,  2048,  4, 3};
    vecs[3]  = '{6,  0,  4,  0,  5,  2,  59, 85,    80,    80,    3, 2};
    vecs[4]  = '{12, 0,  0,  0,  0,  4,  0,  1024,  1024,  1024,  5, 4};
    vecs[5]  = '{13, 0,  0,  0,  0,  5,  0,  130,   128,   128,   6, 5};
    vecs[6]  = '{14, 0,  0,  0,  0,  5,  0,  12,    10,    10,    7, 6};
    vecs[7]  = '{15, 9,  9,  9,  9,  0,  63, 20,    0,     0,     0, -1};
    vecs[8]  = '{9,  0,  0,  3,  0,  1,  0,  0,     1,     0,     2, 1};
    vecs[9]  = '{11, 0,  5,  0,  3,  3,  0,  12,    12,    12,    4, 3};
    vecs[10] = '{8,  255, 0, 0,  0,  0,  0,  765,   765,   765,   1, 0};
    vecs[11] = '{5,  0,  32, 64, 0,  1,  0,  65536, 65536, 65536, 2, 1};

    // Reset holds every output low even with a non-idle layer and all strobes active.
    rst = 1'b1; layer = 4'd14; strb = 6'h3F;
    repeat (3) step();
    check("reset_progress", int'(progress), 0);
    check("reset_phase", int'(phase), 0);
    check("reset_done", int'(done_v), 0);
    check("reset_stall", int'(stall_err), 0);

    // First cycles after release with layer 0 count as INIT entry (target 3*2 = 6).
    layer = 4'd0; input_size = 8'd2; strb = '0;
    rst = 1'b0;
    pulses = 0; pulse_step = 0; stray = 0;
    for (int s = 1; s <= 8; s++) begin
      strb = (s <= 6) ? 6'b000001 : 6'd0;
      step();
      if (init_buffer_done) begin pulses++; pulse_step = s; end
      if ((done_v & 7'b1111110) != 0) stray++;
    end
    strb = '0;
    check("release_init_pulses", pulses, 1);
    check("release_init_step", pulse_step, 6);
    check("release_init_stray", stray, 0);
    check("release_init_progress", int'(progress), 6);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // FC2 interrupted by reset mid-count must restart from zero afterwards.
    layer = 4'd15; strb = '0;
    step();
    layer = 4'd14;
    pulses = 0;
    for (int s = 1; s <= 5; s++) begin
      strb = 6'b100000;
      step();
      if (done_v != 0) pulses++;
    end
    strb = '0;
    check("fc2_partial_progress", int'(progress), 5);
    check("fc2_partial_no_done", pulses, 0);
    rst = 1'b1;
    step();
    check("fc2_rst_progress", int'(progress), 0);
    check("fc2_rst_phase", int'(phase), 0);
    check("fc2_rst_done", int'(done_v), 0);
    rst = 1'b0;
    pulses = 0; pulse_step = 0; stray = 0;
    for (int s = 1; s <= 12; s++) begin
      strb = (s <= 10) ? 6'b100000 : 6'd0;
      step();
      if (fc2_done) begin pulses++; pulse_step = s; end
      if ((done_v & 7'b0111111) != 0) stray++;
    end
    strb = '0;
    check("fc2_after_rst_pulses", pulses, 1);
    check("fc2_after_rst_step", pulse_step, 10);
    check("fc2_after_rst_stray", stray, 0);
    check("fc2_after_rst_progress", int'(progress), 10);
    check("fc2_after_rst_phase", int'(phase), 7);
    check("stall_default_low", int'(stall_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
